// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared widths, buffer depth and FSM states for the FIFO stream reader
package fifo_rd_pkg;
    localparam int DATA_W    = 128;
    localparam int LEN_W     = 16;
    localparam int BUF_DEPTH = 4;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read port plus the outgoing valid/ready stream
interface fifo_stream_reader_if;
    import fifo_rd_pkg::*;
    logic              fifo_rden;
    logic [DATA_W-1:0] fifo_rddata;
    logic              fifo_empty;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              i_ready;
    modport master (output fifo_rden, o_valid, o_data, input fifo_rddata, fifo_empty, i_ready);
    modport slave  (input fifo_rden, o_valid, o_data, output fifo_rddata, fifo_empty, i_ready);
endinterface

// File: rtl/rd_skid_buf.sv
// rd_skid_buf: 4-entry output buffer absorbing FIFO read latency behind a valid/ready stream
module rd_skid_buf
    import fifo_rd_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_acc,
    output logic [2:0]        o_occ
);
    logic [DATA_W-1:0] r_buf [BUF_DEPTH];
    logic [1:0]        r_wr_ptr, r_rd_ptr;
    logic [2:0]        r_occ;

    assign o_valid = r_occ != 3'd0;
    assign o_data  = r_buf[r_rd_ptr];
    assign o_acc   = o_valid & i_ready;
    assign o_occ   = r_occ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_buf    <= '{default: '0};
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_occ    <= 3'd0;
        end else begin
            if (i_wr) begin
                r_buf[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (o_acc) r_rd_ptr <= r_rd_ptr + 2'd1;
            r_occ <= r_occ + {2'b00, i_wr} - {2'b00, o_acc};
        end
    end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pulls FIFO words into a full-throughput valid/ready stream with bounded or open length
module fifo_stream_reader
    import fifo_rd_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [LEN_W-1:0]     i_len,
    input  logic                 i_stop,
    fifo_stream_reader_if.master bus,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [LEN_W-1:0]     o_count
);
    state_t            r_state, w_next;
    logic [LEN_W-1:0]  r_len, r_issued, r_count;
    logic              r_inflight, r_done;
    logic              w_rden, w_last, w_drained, w_acc, w_valid;
    logic [DATA_W-1:0] w_data;
    logic [2:0]        w_occ;

    rd_skid_buf u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_wr    (r_inflight),
        .i_wdata (bus.fifo_rddata),
        .i_ready (bus.i_ready),
        .o_valid (w_valid),
        .o_data  (w_data),
        .o_acc   (w_acc),
        .o_occ   (w_occ)
    );

    assign bus.fifo_rden = w_rden;
    assign bus.o_valid   = w_valid;
    assign bus.o_data    = w_data;
    assign o_busy        = r_state != IDLE;
    assign o_done        = r_done;
    assign o_count       = r_count;

    // Read issue reserves a buffer slot per outstanding read, so i_ready never enters this path
    always_comb begin
        w_rden    = (r_state == RUN) & !bus.fifo_empty & (w_occ + {2'b00, r_inflight} < 3'(BUF_DEPTH))
                    & !i_stop & (r_len == '0 | r_issued < r_len);
        w_last    = w_rden & (r_len != '0) & (r_issued + LEN_W'(1) == r_len);
        w_drained = !r_inflight & (w_occ == 3'd0 | (w_occ == 3'd1 & w_acc));
        w_next    = (r_state == IDLE) ? (i_start ? RUN : IDLE)
                  : (r_state == RUN)  ? ((i_stop | w_last) ? FLUSH : RUN)
                  : (w_drained ? IDLE : FLUSH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_issued   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_rden;
            r_done     <= (r_state == FLUSH) & (w_next == IDLE);
            if (r_state == IDLE & i_start) begin
                r_len    <= i_len;
                r_issued <= '0;
                r_count  <= '0;
            end else begin
                if (w_rden) r_issued <= r_issued + LEN_W'(1);
                if (w_acc) r_count <= r_count + LEN_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed scenarios with random data/ready against a FIFO model and an in-order scoreboard
module tb_fifo_stream_reader;
    import fifo_rd_pkg::*;

    logic             clk = 1'b0;
    logic             reset, i_start, i_stop;
    logic [LEN_W-1:0] i_len;
    logic             o_busy, o_done;
    logic [LEN_W-1:0] o_count;

    fifo_stream_reader_if bus ();

    fifo_stream_reader dut (
        .clk     (clk),
        .reset   (reset),
        .i_start (i_start),
        .i_len   (i_len),
        .i_stop  (i_stop),
        .bus     (bus.master),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_count (o_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, cyc = 0, rdy_mode = 0;
    int n_rd = 0, n_acc = 0, first_rd = 0, last_rd = 0, first_acc = 0, last_acc = 0;
    int c0 = 0, done_seen = 0, t, s;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic [DATA_W-1:0] fq[$], exp_q[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_d(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.i_ready = rdy_mode == 0 ? 1'b1
                    : rdy_mode == 1 ? (cyc % 3 == 0)
                    : rdy_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic push_rand(input int n);
        repeat (n) push({$urandom(), $urandom(), $urandom(), $urandom()});
    endtask

    task automatic start_xfer(input logic [LEN_W-1:0] len, input logic stop);
        tick();
        i_start   = 1'b1;
        i_len     = len;
        i_stop    = stop;
        c0        = cyc;
        exp_q     = fq;
        n_rd      = 0;
        n_acc     = 0;
        done_seen = 0;
        tick();
        i_start = 1'b0;
        i_stop  = 1'b0;
        @(negedge clk);
        check("busy_after_start", int'(o_busy), 1);
    endtask

    task automatic wait_done(input int max);
        int k = 0;
        while (done_seen == 0 && k < max) begin
            tick();
            k++;
        end
        check("done_seen", done_seen, 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // FIFO read-port model: data appears the cycle after rden, flag reflects the post-pop content
    initial forever begin
        @(posedge clk);
        if (bus.fifo_rden && fq.size() > 0) bus.fifo_rddata <= fq.pop_front();
        bus.fifo_empty <= fq.size() == 0;
    end

    initial forever begin
        @(negedge clk);
        if (!reset) prev_stall = 1'b0;
        else begin
            if (bus.fifo_rden) begin
                check("no_read_when_empty", int'(bus.fifo_empty), 0);
                if (n_rd == 0) first_rd = cyc;
                last_rd = cyc;
                n_rd++;
            end
            if (prev_stall) begin
                check("stall_valid_held", int'(bus.o_valid), 1);
                check_d("stall_data_held", bus.o_data, prev_data);
            end
            if (bus.o_valid && bus.i_ready) begin
                check("scoreboard_has_word", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check_d("stream_data", bus.o_data, exp_q.pop_front());
                if (n_acc == 0) first_acc = cyc;
                last_acc = cyc;
                n_acc++;
            end
            check("outstanding_le4", int'(n_rd - n_acc <= 4), 1);
            if (o_done) begin
                done_seen = 1;
                check("done_not_busy", int'(o_busy), 0);
                if (n_acc > 0) check("done_latency", cyc, last_acc + 1);
            end
            prev_stall = bus.o_valid & !bus.i_ready;
            prev_data  = bus.o_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no summary expected finish before timeout");
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        i_start     = 1'b0;
        i_stop      = 1'b0;
        i_len       = '0;
        bus.i_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rden", int'(bus.fifo_rden), 0);
        check("rst_valid", int'(bus.o_valid), 0);
        check_d("rst_data", bus.o_data, '0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_count", int'(o_count), 0);
        tick();
        reset = 1'b1;

        // basic 8-word transfer
        for (int i = 0; i < 8; i++) push(DATA_W'(i));
        tick();
        tick();
        start_xfer(16'd8, 1'b0);
        wait_done(60);
        check("basic_reads", n_rd, 8);
        check("basic_accepts", n_acc, 8);
        check("basic_count", int'(o_count), 8);
        check("basic_first_rden", first_rd, c0 + 1);
        check("basic_rden_burst", last_rd - first_rd, 7);
        check("basic_first_valid", first_acc, c0 + 3);
        check("basic_back_to_back", last_acc - first_acc, 7);

        // backpressure, ready one cycle in three
        rdy_mode = 1;
        fq = {};
        push_rand(20);
        tick();
        tick();
        start_xfer(16'd16, 1'b0);
        wait_done(200);
        check("bp_reads", n_rd, 16);
        check("bp_accepts", n_acc, 16);
        check("bp_count", int'(o_count), 16);
        check("bp_fifo_left", fq.size(), 4);

        // continuous mode across an empty gap, then stop
        rdy_mode = 2;
        fq = {};
        push_rand(6);
        tick();
        tick();
        start_xfer(16'd0, 1'b0);
        t = 0;
        while (n_acc < 6 && t < 200) begin tick(); t++; end
        check("gap_drained", n_acc, 6);
        repeat (5) tick();
        check("gap_no_reads", n_rd, 6);
        check("gap_busy", int'(o_busy), 1);
        push_rand(12);
        t = 0;
        while (n_rd < 10 && t < 100) begin tick(); t++; end
        check("gap_resumed", int'(n_rd >= 10), 1);
        i_stop = 1'b1;
        s = n_rd;
        tick();
        i_stop = 1'b0;
        wait_done(200);
        check("gap_stop_reads", n_rd, s);
        check("gap_flush_delivered", n_acc, s);
        check("gap_count", int'(o_count), s);

        // early stop one cycle after the third read
        rdy_mode = 0;
        fq = {};
        push_rand(10);
        tick();
        tick();
        start_xfer(16'd10, 1'b0);
        t = 0;
        while (n_rd < 3 && t < 50) begin @(negedge clk); #1; t++; end
        tick();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        wait_done(50);
        check("stop_reads", n_rd, 3);
        check("stop_accepts", n_acc, 3);
        check("stop_count", int'(o_count), 3);
        check("stop_fifo_left", fq.size(), 7);

        // asynchronous reset with two words buffered
        rdy_mode = 3;
        fq = {};
        push_rand(2);
        tick();
        tick();
        start_xfer(16'd0, 1'b0);
        repeat (4) tick();
        check("pre_rst_valid", int'(bus.o_valid), 1);
        check("pre_rst_reads", n_rd, 2);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("arst_rden", int'(bus.fifo_rden), 0);
        check("arst_valid", int'(bus.o_valid), 0);
        check_d("arst_data", bus.o_data, '0);
        check("arst_busy", int'(o_busy), 0);
        check("arst_done", int'(o_done), 0);
        check("arst_count", int'(o_count), 0);
        fq = {};
        exp_q = {};
        repeat (2) tick();
        reset = 1'b1;
        rdy_mode = 0;
        push_rand(4);
        tick();
        tick();
        start_xfer(16'd4, 1'b0);
        wait_done(50);
        check("post_rst_accepts", n_acc, 4);
        check("post_rst_count", int'(o_count), 4);

        // i_start during RUN ignored
        rdy_mode = 2;
        fq = {};
        push_rand(6);
        tick();
        tick();
        start_xfer(16'd6, 1'b0);
        tick();
        i_start = 1'b1;
        i_len   = 16'd2;
        tick();
        i_start = 1'b0;
        wait_done(100);
        check("run_start_reads", n_rd, 6);
        check("run_start_count", int'(o_count), 6);

        // i_stop during IDLE ignored
        tick();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        @(negedge clk);
        check("idle_stop_busy", int'(o_busy), 0);
        check("idle_stop_done", int'(o_done), 0);
        check("idle_stop_count", int'(o_count), 6);

        // start and stop together in IDLE: start wins
        fq = {};
        push_rand(3);
        tick();
        tick();
        start_xfer(16'd3, 1'b1);
        wait_done(60);
        check("start_stop_reads", n_rd, 3);
        check("start_stop_count", int'(o_count), 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
